// File: rtl/sump_response_tx.sv
// ----------------------------------------------------------------------------
// sump_response_tx
//
// Device-to-host half of the SUMP serial link. Answers ID and metadata
// queries and streams captured sample bytes, all serialized as UART 8N1.
//
// Ports:
//   system_clock  sole clock
//   ext_reset     asynchronous, active-high reset
//   id_req        one-cycle pulse: queue the ID response ("1ALS")
//   meta_req      one-cycle pulse: queue the metadata response
//   abort         one-cycle pulse: drop queued work, finish the current frame
//   smp_data      sample byte from capture memory readout
//   smp_valid     smp_data is valid
//   smp_ready     sample byte accepted when smp_valid & smp_ready
//   tx            UART line, idle high, registered
//   busy          a frame is in flight or a request is pending
//
// Bit FSM:
//   state | meaning
//   IDLE  | line idle, arbitrating requests / accepting a sample byte
//   START | driving the start bit (0)
//   DATA  | driving d[bit_idx], LSB first
//   STOP  | driving the stop bit (1); at its end pick the next byte
// ----------------------------------------------------------------------------
module sump_response_tx #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned NUM_PROBES   = 8,
    parameter logic [31:0] MEM_DEPTH    = 32'h0000_2000,
    parameter logic [31:0] MAX_RATE_HZ  = 32'd100_000_000
) (
    input  logic       system_clock,
    input  logic       ext_reset,
    input  logic       id_req,
    input  logic       meta_req,
    input  logic       abort,
    input  logic [7:0] smp_data,
    input  logic       smp_valid,
    output logic       smp_ready,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    typedef enum logic [1:0] {RESP_NONE, RESP_ID, RESP_META, RESP_SMP} resp_t;

    localparam logic [15:0] BAUD_RELOAD  = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  ID_LAST      = 5'd3;
    localparam logic [4:0]  META_LAST    = 5'd20;
    localparam logic [7:0]  NUM_PROBES_B = 8'(NUM_PROBES);

    state_t      state;
    resp_t       resp;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [4:0]  byte_idx;
    logic [7:0]  shreg;
    logic        pend_id;
    logic        pend_meta;
    logic        resp_kill;

    logic        baud_tc;
    logic        frame_end;
    logic        abort_eff;
    logic        resp_last;
    logic        continue_resp;
    logic        arb_point;
    logic        id_yield;
    resp_t       arb_pick;
    logic        start_resp;
    logic        clr_id;
    logic        clr_meta;
    logic        smp_accept;

    function automatic logic [7:0] resp_byte(input resp_t r, input logic [4:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (r == RESP_ID) begin
            case (idx)
                5'd0:    b = 8'h31;
                5'd1:    b = 8'h41;
                5'd2:    b = 8'h4C;
                5'd3:    b = 8'h53;
                default: b = 8'h00;
            endcase
        end else if (r == RESP_META) begin
            case (idx)
                5'd0:    b = 8'h01;
                5'd1:    b = 8'h41;
                5'd2:    b = 8'h43;
                5'd3:    b = 8'h53;
                5'd4:    b = 8'h50;
                5'd5:    b = 8'h00;
                5'd6:    b = 8'h21;
                5'd7:    b = MEM_DEPTH[31:24];
                5'd8:    b = MEM_DEPTH[23:16];
                5'd9:    b = MEM_DEPTH[15:8];
                5'd10:   b = MEM_DEPTH[7:0];
                5'd11:   b = 8'h23;
                5'd12:   b = MAX_RATE_HZ[31:24];
                5'd13:   b = MAX_RATE_HZ[23:16];
                5'd14:   b = MAX_RATE_HZ[15:8];
                5'd15:   b = MAX_RATE_HZ[7:0];
                5'd16:   b = 8'h40;
                5'd17:   b = NUM_PROBES_B;
                5'd18:   b = 8'h41;
                5'd19:   b = 8'h02;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    assign baud_tc    = (baud_cnt == 16'd0);
    assign frame_end  = (state == STOP) && baud_tc;
    // Abort only has meaning while something is on the wire.
    assign abort_eff  = abort && (state != IDLE);
    assign smp_ready  = (state == IDLE) && !pend_id && !pend_meta && !abort && !ext_reset;
    assign smp_accept = smp_valid && smp_ready;
    assign busy       = (state != IDLE) || pend_id || pend_meta;

    always_comb begin
        case (resp)
            RESP_ID:   resp_last = (byte_idx == ID_LAST);
            RESP_META: resp_last = (byte_idx == META_LAST);
            default:   resp_last = 1'b1;
        endcase
    end

    assign continue_resp = frame_end && !resp_kill && !abort && !resp_last;
    assign arb_point     = (state == IDLE) || (frame_end && !continue_resp);

    // An ID request re-raised while ID is being sent queues behind a pending
    // metadata request, so the host sees ID, metadata, then ID again.
    assign id_yield = pend_meta && (state == STOP) && (resp == RESP_ID);

    always_comb begin
        arb_pick = RESP_NONE;
        if (!abort_eff) begin
            if (pend_id && !id_yield) begin
                arb_pick = RESP_ID;
            end else if (pend_meta) begin
                arb_pick = RESP_META;
            end
        end
    end

    assign start_resp = arb_point && (arb_pick != RESP_NONE);
    assign clr_id     = start_resp && (arb_pick == RESP_ID);
    assign clr_meta   = start_resp && (arb_pick == RESP_META);

    always_ff @(posedge system_clock or posedge ext_reset) begin
        if (ext_reset) begin
            state     <= IDLE;
            resp      <= RESP_NONE;
            baud_cnt  <= 16'd0;
            bit_idx   <= 3'd0;
            byte_idx  <= 5'd0;
            shreg     <= 8'h00;
            pend_id   <= 1'b0;
            pend_meta <= 1'b0;
            resp_kill <= 1'b0;
            tx        <= 1'b1;
        end else begin
            // A new request always wins over a same-cycle clear or abort.
            pend_id   <= id_req   || (pend_id   && !clr_id   && !abort_eff);
            pend_meta <= meta_req || (pend_meta && !clr_meta && !abort_eff);

            if (abort_eff) begin
                resp_kill <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_resp) begin
                        state     <= START;
                        tx        <= 1'b0;
                        baud_cnt  <= BAUD_RELOAD;
                        resp      <= arb_pick;
                        byte_idx  <= 5'd0;
                        shreg     <= resp_byte(arb_pick, 5'd0);
                        resp_kill <= 1'b0;
                    end else if (smp_accept) begin
                        state     <= START;
                        tx        <= 1'b0;
                        baud_cnt  <= BAUD_RELOAD;
                        resp      <= RESP_SMP;
                        byte_idx  <= 5'd0;
                        shreg     <= smp_data;
                        resp_kill <= 1'b0;
                    end
                end

                START: begin
                    if (baud_tc) begin
                        state    <= DATA;
                        tx       <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_idx  <= 3'd0;
                        baud_cnt <= BAUD_RELOAD;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end

                DATA: begin
                    if (baud_tc) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end

                STOP: begin
                    if (baud_tc) begin
                        if (continue_resp) begin
                            state    <= START;
                            tx       <= 1'b0;
                            baud_cnt <= BAUD_RELOAD;
                            byte_idx <= byte_idx + 5'd1;
                            shreg    <= resp_byte(resp, byte_idx + 5'd1);
                        end else if (start_resp) begin
                            state     <= START;
                            tx        <= 1'b0;
                            baud_cnt  <= BAUD_RELOAD;
                            resp      <= arb_pick;
                            byte_idx  <= 5'd0;
                            shreg     <= resp_byte(arb_pick, 5'd0);
                            resp_kill <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            resp     <= RESP_NONE;
                            byte_idx <= 5'd0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sump_response_tx.sv
// ----------------------------------------------------------------------------
// tb_sump_response_tx
//
// Directed bench for sump_response_tx with CLKS_PER_BIT=16. A simple UART
// receiver samples tx at bit centres against hand-written byte tables.
// ----------------------------------------------------------------------------
module tb_sump_response_tx;

    localparam int CPB = 16;

    logic       system_clock = 1'b0;
    logic       ext_reset    = 1'b1;
    logic       id_req       = 1'b0;
    logic       meta_req     = 1'b0;
    logic       abort        = 1'b0;
    logic [7:0] smp_data     = 8'h00;
    logic       smp_valid    = 1'b0;
    logic       smp_ready;
    logic       tx;
    logic       busy;

    int errors   = 0;
    int checks   = 0;
    int sched_id = -1;
    int sched_ab = -1;

    logic [7:0] id_bytes [4]   = '{8'h31, 8'h41, 8'h4C, 8'h53};
    logic [7:0] meta_bytes [21] = '{8'h01, 8'h41, 8'h43, 8'h53, 8'h50, 8'h00,
                                    8'h21, 8'h00, 8'h00, 8'h20, 8'h00,
                                    8'h23, 8'h05, 8'hF5, 8'hE1, 8'h00,
                                    8'h40, 8'h08, 8'h41, 8'h02, 8'h00};

    sump_response_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_PROBES(8),
        .MEM_DEPTH(32'h0000_2000),
        .MAX_RATE_HZ(32'd100_000_000)
    ) dut (
        .system_clock(system_clock),
        .ext_reset(ext_reset),
        .id_req(id_req),
        .meta_req(meta_req),
        .abort(abort),
        .smp_data(smp_data),
        .smp_valid(smp_valid),
        .smp_ready(smp_ready),
        .tx(tx),
        .busy(busy)
    );

    always #5 system_clock = ~system_clock;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; pulses driven before the edge last exactly one cycle.
    task automatic tick();
        @(posedge system_clock);
        #1;
        id_req   = 1'b0;
        meta_req = 1'b0;
        abort    = 1'b0;
        if (sched_id == 0) id_req = 1'b1;
        if (sched_id >= 0) sched_id--;
        if (sched_ab == 0) abort = 1'b1;
        if (sched_ab >= 0) sched_ab--;
    endtask

    // Receive one frame. Called at the first cycle the start bit may be on the
    // line; with max_wait=0 the start bit must already be there (no gap).
    // Returns exactly 10*CPB cycles after the start bit began.
    task automatic rx_frame(input logic [7:0] exp, input int max_wait, input string tag);
        int w;
        logic [7:0] got;
        w = 0;
        while (tx !== 1'b0 && w < max_wait) begin
            tick();
            w++;
        end
        chk(tx, 1'b0, {tag, " start edge"});
        if (tx !== 1'b0) return;
        repeat (CPB / 2) tick();
        chk(tx, 1'b0, {tag, " start mid"});
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) tick();
            got[i] = tx;
        end
        chk(got, exp, {tag, " data"});
        repeat (CPB) tick();
        chk(tx, 1'b1, {tag, " stop"});
        chk(busy, 1'b1, {tag, " busy in frame"});
        repeat (CPB / 2) tick();
    endtask

    task automatic rx_id(input string tag);
        for (int i = 0; i < 4; i++) rx_frame(id_bytes[i], 0, $sformatf("%s id%0d", tag, i));
    endtask

    task automatic rx_meta(input string tag);
        for (int i = 0; i < 21; i++) rx_frame(meta_bytes[i], 0, $sformatf("%s meta%0d", tag, i));
    endtask

    initial begin
        int tx_low;

        // Reset state
        repeat (3) tick();
        chk(tx, 1'b1, "rst tx");
        chk(busy, 1'b0, "rst busy");
        chk(smp_ready, 1'b0, "rst ready");
        ext_reset = 1'b0;
        tick();
        chk(smp_ready, 1'b1, "idle ready");
        chk(tx, 1'b1, "idle tx");

        // ID response: latency, four gapless frames, busy falls at the end
        id_req = 1'b1;
        tick();
        chk(tx, 1'b1, "id latch tx");
        chk(busy, 1'b1, "id latch busy");
        tick();
        chk(tx, 1'b0, "id latency");
        rx_id("t1");
        chk(busy, 1'b0, "t1 busy end");
        chk(tx, 1'b1, "t1 tx end");

        // Metadata response
        meta_req = 1'b1;
        tick();
        tick();
        chk(tx, 1'b0, "meta latency");
        rx_meta("t2");
        chk(busy, 1'b0, "t2 busy end");

        // ID + metadata together; second ID request during ID byte 1
        id_req   = 1'b1;
        meta_req = 1'b1;
        tick();
        tick();
        chk(tx, 1'b0, "t3 latency");
        rx_frame(id_bytes[0], 0, "t3 id0");
        sched_id = 20;
        for (int i = 1; i < 4; i++) rx_frame(id_bytes[i], 0, $sformatf("t3 id%0d", i));
        rx_meta("t3");
        rx_id("t3b");
        chk(busy, 1'b0, "t3 busy end");

        // Samples, with an ID request during the first sample frame
        smp_data  = 8'hA5;
        smp_valid = 1'b1;
        #1;
        chk(smp_ready, 1'b1, "t4 ready A5");
        tick();
        chk(smp_ready, 1'b0, "t4 ready drop A5");
        smp_data = 8'h3C;
        sched_id = 30;
        rx_frame(8'hA5, 0, "t4 A5");
        chk(smp_ready, 1'b0, "t4 ready during id");
        rx_id("t4");
        chk(busy, 1'b0, "t4 busy before 3C");
        chk(smp_ready, 1'b1, "t4 ready 3C");
        tick();
        chk(smp_ready, 1'b0, "t4 ready drop 3C");
        smp_valid = 1'b0;
        rx_frame(8'h3C, 0, "t4 3C");
        chk(busy, 1'b0, "t4 busy end");

        // Abort during metadata byte 5
        meta_req = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) rx_frame(meta_bytes[i], 0, $sformatf("t5 meta%0d", i));
        sched_ab = 40;
        rx_frame(meta_bytes[5], 0, "t5 meta5");
        chk(tx, 1'b1, "t5 tx after abort");
        chk(busy, 1'b0, "t5 busy after abort");
        chk(smp_ready, 1'b1, "t5 ready after abort");
        tx_low = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            tick();
            if (tx !== 1'b1) tx_low++;
        end
        chk(tx_low, 0, "t5 line quiet");

        // Reset in the middle of the data bits
        id_req = 1'b1;
        tick();
        tick();
        repeat (3 * CPB) tick();
        ext_reset = 1'b1;
        #1;
        chk(tx, 1'b1, "t6 async tx");
        chk(busy, 1'b0, "t6 async busy");
        repeat (2) tick();
        ext_reset = 1'b0;
        tick();
        chk(tx, 1'b1, "t6 post-reset tx");
        chk(busy, 1'b0, "t6 post-reset busy");
        id_req = 1'b1;
        tick();
        tick();
        chk(tx, 1'b0, "t6 latency");
        rx_id("t6");
        chk(busy, 1'b0, "t6 busy end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
